rx_capture_ctrl: RTL and testbench
==================================

Name: rx_capture_ctrl

Overview:
- Parametrised capture controller between the DDC output (I/Q + valid) and the sample RAM/FIFO write port.
- On each START it clears the FIFO, then writes PULSE_LEN I/Q samples to consecutive addresses from BASE_ADDR, then writes a status header word at HDR_ADDR.
- Re-armable across captures, with write backpressure and overrun detection.

Parameters:
DATA_W, 16, width of each of I and Q; WR_DATA is 2*DATA_W
ADDR_W, 16, write address width
LEN_W, 16, width of PULSE_LEN and the sample counter
BASE_ADDR, 500, address of sample 0
HDR_ADDR, 499, address of the status header word
MAX_LEN, 4096, PULSE_LEN values above this are clamped to MAX_LEN
CLR_CYCLES, 4, number of cycles FIFO_ACLR is held per capture (>=1)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
START  in  1  one-cycle pulse that arms a capture; ignored while BUSY=1
PULSE_LEN  in  LEN_W  sample count, sampled on the accepted START
IDATA  in  DATA_W  DDC I sample
QDATA  in  DATA_W  DDC Q sample
IQ_VALID  in  1  I/Q valid strobe, one cycle per sample
WR_ADDR  out  ADDR_W  write address
WR_DATA  out  2*DATA_W  write data, {IDATA,QDATA} or header
WR_EN  out  1  write request, held until accepted
WR_READY  in  1  sink accepts when WR_EN&WR_READY at a rising CLK
FIFO_ACLR  out  1  FIFO clear
BUSY  out  1  high from accepted START until DONE
DONE  out  1  one-cycle completion pulse
OVERRUN  out  1  sticky per capture: a sample was dropped
SAMPLE_CNT  out  LEN_W  samples accepted so far in the current capture

Behaviour:
- Reset: all outputs are 0 except FIFO_ACLR=1; state IDLE.
- IDLE: FIFO_ACLR=0 and BUSY=0.
  - START=1 -> latch len=min(PULSE_LEN,MAX_LEN).
  - Same edge: clear SAMPLE_CNT and OVERRUN, set BUSY=1, go to CLEAR.
- CLEAR: FIFO_ACLR=1 for exactly CLR_CYCLES cycles, then deassert it.
  - Next state is CAPTURE, or HEADER if len==0.
- CAPTURE:
  - IQ_VALID with no write pending -> next cycle WR_EN=1, WR_DATA={IDATA,QDATA}, WR_ADDR=(BASE_ADDR+SAMPLE_CNT) mod 2^ADDR_W. Latency is 1 cycle.
  - WR_EN, WR_ADDR and WR_DATA stay stable until WR_EN&WR_READY.
  - On acceptance SAMPLE_CNT increments.
  - Accept and IQ_VALID on the same edge -> the new write issues the next cycle (back-to-back, no bubble).
  - IQ_VALID while a write is pending and not accepted that edge -> the sample is dropped, OVERRUN=1, SAMPLE_CNT unchanged.
  - IQ_VALID during IDLE, CLEAR, HEADER or DONE is ignored and does not set OVERRUN.
  - Acceptance that makes SAMPLE_CNT==len -> go to HEADER. Samples arriving after that are ignored.
- HEADER:
  - WR_ADDR=HDR_ADDR.
  - WR_DATA bit[2*DATA_W-1]=OVERRUN; bits[LEN_W-1:0]=SAMPLE_CNT; all other bits 0.
  - Held until accepted, then go to DONE.
- DONE: DONE=1 and BUSY=0 for one cycle, then IDLE. START in this cycle is ignored.
- SAMPLE_CNT and OVERRUN hold their values after DONE until the next accepted START.
- RESET asserted mid-capture aborts immediately to reset values. No header is written.
- Address arithmetic wraps modulo 2^ADDR_W and is never saturated.

Optional Feature:
RX_TIMESTAMP_EN
- Defined:
  - A free-running 32-bit counter (cleared by RESET) is captured at the first accepted sample. With len==0 it is captured on entering HEADER.
  - After the status header, a second header write goes to HDR_ADDR-1 with data = the timestamp, zero-extended or truncated to 2*DATA_W. This write uses the same handshake.
  - DONE follows acceptance of the second write.
- Undefined: no counter and a single header write, as above.

Test Plan:
- PULSE_LEN=3, WR_READY=1, 3 spaced IQ_VALIDs (I=0x0001..3, Q=0x0010..30) -> writes 500:0x00010010, 501:0x00020020, 502:0x00030030, 499:0x00000003; DONE 1 cycle; OVERRUN=0.
- PULSE_LEN=2, WR_READY=0 for 5 cycles after first write, second IQ_VALID during stall -> sample dropped, OVERRUN=1; a third IQ_VALID after the stall is written to 501; header 499:0x80000002.
- PULSE_LEN=0 -> FIFO_ACLR high 4 cycles, only write is 499:0x00000000, then DONE.
- PULSE_LEN=5000 (MAX_LEN=4096) -> 4096 samples to 500..4595, header low bits 0x1000. START pulses mid-capture are ignored (BUSY stays 1).
- RESET pulse after 2 of 4 samples -> all outputs at reset values, FIFO_ACLR=1, no header. New START with PULSE_LEN=1 -> write 500 then 499:0x00000001.
- Continuous IQ_VALID every cycle with WR_READY=1, PULSE_LEN=4 -> 4 back-to-back writes on consecutive cycles to 500..503, OVERRUN=0.

Source files
------------

// File: rtl/rx_capture_ctrl.sv
// rx_capture_ctrl: capture controller between the DDC I/Q output and a sample-RAM write port.
// Each accepted START clears the FIFO for CLR_CYCLES cycles. It then writes up to
// min(PULSE_LEN, MAX_LEN) samples to BASE_ADDR onward and finishes with a status header
// at HDR_ADDR.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   start_i             capture arm pulse (ignored while busy or in the done cycle)
//   pulse_len_i         requested sample count, latched on the accepted start
//   idata_i, qdata_i    I/Q sample, iq_valid_i one-cycle strobe per sample
//   wr_addr_o/wr_data_o/wr_en_o, wr_ready_i   write port with valid/ready handshake
//   fifo_aclr_o         FIFO clear (high in reset and during the clear phase)
//   busy_o, done_o      capture in progress / one-cycle completion pulse
//   overrun_o           sticky per capture: a sample arrived while a write was stalled
//   sample_cnt_o        samples accepted in the current capture
//
// Optional build macro RX_TIMESTAMP_EN: adds a free-running 32-bit timestamp. The timestamp
// is captured at the first accepted sample, or on entering the header for a zero-length
// capture. It is written to HDR_ADDR-1 after the status header.
module rx_capture_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned BASE_ADDR  = 500,
    parameter int unsigned HDR_ADDR   = 499,
    parameter int unsigned MAX_LEN    = 4096,
    parameter int unsigned CLR_CYCLES = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [LEN_W-1:0]    pulse_len_i,
    input  logic [DATA_W-1:0]   idata_i,
    input  logic [DATA_W-1:0]   qdata_i,
    input  logic                iq_valid_i,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [2*DATA_W-1:0] wr_data_o,
    output logic                wr_en_o,
    input  logic                wr_ready_i,
    output logic                fifo_aclr_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                overrun_o,
    output logic [LEN_W-1:0]    sample_cnt_o
);

    localparam int unsigned WD_W  = 2 * DATA_W;
    localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StClear, StCapture, StHeader, StTs, StDone} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovr_q, ovr_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [WD_W-1:0]    wr_data_q, wr_data_d;
    logic               aclr_q;
    logic               accept;
    logic               clr_last;
    logic [WD_W-1:0]    hdr_data;
    logic [WD_W-1:0]    ts_data;

    assign accept   = wr_en_q & wr_ready_i;
    assign clr_last = (clr_cnt_q == CLR_W'(CLR_CYCLES - 1));

`ifdef RX_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] ts_q;
    logic        ts_load;

    assign ts_load = (state_q == StCapture && accept && cnt_q == '0) ||
                     (state_q == StClear && clr_last && len_q == '0);
    assign ts_data = WD_W'(ts_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_cnt_q <= '0;
            ts_q     <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (ts_load) ts_q <= ts_cnt_q;
        end
    end
`else
    assign ts_data = '0;
`endif

    // Header word: overrun flag in the MSB, sample count in the low bits.
    always_comb begin
        hdr_data             = '0;
        hdr_data[LEN_W-1:0]  = cnt_q;
        hdr_data[WD_W-1]     = ovr_q;
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
        clr_cnt_d = clr_cnt_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    len_d     = (pulse_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pulse_len_i;
                    cnt_d     = '0;
                    ovr_d     = 1'b0;
                    clr_cnt_d = '0;
                    state_d   = StClear;
                end
            end
            StClear: begin
                clr_cnt_d = clr_cnt_q + CLR_W'(1);
                if (clr_last) state_d = (len_q == '0) ? StHeader : StCapture;
            end
            StCapture: begin
                if (accept) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) begin
                        // Last sample written; any sample on this edge is surplus.
                        wr_en_d = 1'b0;
                        state_d = StHeader;
                    end else if (iq_valid_i) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_d);
                        wr_data_d = {idata_i, qdata_i};
                    end else begin
                        wr_en_d = 1'b0;
                    end
                end else if (iq_valid_i) begin
                    if (wr_en_q) begin
                        ovr_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt_q);
                        wr_data_d = {idata_i, qdata_i};
                    end
                end
            end
            StHeader: begin
                if (wr_ready_i) begin
`ifdef RX_TIMESTAMP_EN
                    state_d = StTs;
`else
                    state_d = StDone;
`endif
                end
            end
            StTs: begin
                if (wr_ready_i) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            len_q     <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            clr_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            aclr_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            clr_cnt_q <= clr_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            aclr_q    <= (state_d == StClear);
        end
    end

    // Sample writes come from registers; header writes are muxed from stable state.
    always_comb begin
        wr_en_o   = wr_en_q;
        wr_addr_o = wr_addr_q;
        wr_data_o = wr_data_q;
        if (state_q == StHeader) begin
            wr_en_o   = 1'b1;
            wr_addr_o = ADDR_W'(HDR_ADDR);
            wr_data_o = hdr_data;
        end else if (state_q == StTs) begin
            wr_en_o   = 1'b1;
            wr_addr_o = ADDR_W'(HDR_ADDR - 1);
            wr_data_o = ts_data;
        end
    end

    assign fifo_aclr_o  = aclr_q;
    assign busy_o       = (state_q == StClear) || (state_q == StCapture) ||
                          (state_q == StHeader) || (state_q == StTs);
    assign done_o       = (state_q == StDone);
    assign overrun_o    = ovr_q;
    assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_rx_capture_ctrl.sv
module tb_rx_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pulse_len = '0;
    logic [15:0] idata = '0;
    logic [15:0] qdata = '0;
    logic        iq_valid = 1'b0;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        wr_ready = 1'b1;
    logic        fifo_aclr;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [15:0] sample_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];
    int   wr_cyc[$];

    rx_capture_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .pulse_len_i  (pulse_len),
        .idata_i      (idata),
        .qdata_i      (qdata),
        .iq_valid_i   (iq_valid),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_en_o      (wr_en),
        .wr_ready_i   (wr_ready),
        .fifo_aclr_o  (fifo_aclr),
        .busy_o       (busy),
        .done_o       (done),
        .overrun_o    (overrun),
        .sample_cnt_o (sample_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: a write seen with wr_en&wr_ready here is accepted at the next rising edge.
    always @(negedge clk) begin
        if (!rst && wr_en && wr_ready) begin
            exp_t e;
            wr_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write",
                         wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                if (wr_addr !== e.addr || (e.chk_data && wr_data !== e.data)) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [31:0] d);
        sb.push_back('{addr: a, data: d, chk_data: 1'b1});
    endtask

    task automatic push_hdr(input logic [31:0] d);
        push(16'd499, d);
`ifdef RX_TIMESTAMP_EN
        sb.push_back('{addr: 16'd498, data: 32'd0, chk_data: 1'b0});
`endif
    endtask

    task automatic do_start(input logic [15:0] len);
        start     = 1'b1;
        pulse_len = len;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (fifo_aclr === 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: got done=%b after %0d cycles, expected 1", done, n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b, expected 0", busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if ({wr_en, busy, done, overrun, fifo_aclr} !== 5'b00001 || sample_cnt !== 16'd0 ||
            wr_addr !== 16'd0 || wr_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got en=%b busy=%b done=%b ovr=%b aclr=%b cnt=%h, expected 0 0 0 0 1 0",
                     wr_en, busy, done, overrun, fifo_aclr, sample_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (fifo_aclr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_state: got aclr=%b busy=%b, expected 0 0", fifo_aclr, busy);
        end
    endtask

    task automatic test_basic();
        int n;
        for (int i = 1; i <= 3; i++) push(16'(499 + i), {16'(i), 16'(i * 16)});
        push_hdr(32'h0000_0003);
        do_start(16'd3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b, expected 1", busy);
        end
        wait_clear(n);
        for (int i = 1; i <= 3; i++) begin
            idata    = 16'(i);
            qdata    = 16'(i * 16);
            iq_valid = 1'b1;
            tick();
            iq_valid = 1'b0;
            tick();
            tick();
        end
        wait_done(50);
        checks++;
        if (overrun !== 1'b0 || sample_cnt !== 16'd3) begin
            errors++;
            $display("FAIL basic_status: got ovr=%b cnt=%0d, expected 0 3", overrun, sample_cnt);
        end
    endtask

    task automatic test_overrun();
        int n;
        push(16'd500, 32'hAAAA_0001);
        push(16'd501, 32'hCCCC_0003);
        push_hdr(32'h8000_0002);
        do_start(16'd2);
        wait_clear(n);
        wr_ready = 1'b0;
        idata    = 16'hAAAA;
        qdata    = 16'h0001;
        iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        tick();
        idata    = 16'hBBBB;
        qdata    = 16'h0002;
        iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1 || sample_cnt !== 16'd0) begin
            errors++;
            $display("FAIL overrun_flag: got ovr=%b cnt=%0d, expected 1 0", overrun, sample_cnt);
        end
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 16'd500 || wr_data !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL stall_hold: got en=%b addr=%h data=%h, expected 1 01f4 aaaa0001",
                     wr_en, wr_addr, wr_data);
        end
        tick();
        tick();
        wr_ready = 1'b1;
        tick();
        tick();
        idata    = 16'hCCCC;
        qdata    = 16'h0003;
        iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        wait_done(50);
        checks++;
        if (overrun !== 1'b1 || sample_cnt !== 16'd2) begin
            errors++;
            $display("FAIL overrun_status: got ovr=%b cnt=%0d, expected 1 2", overrun, sample_cnt);
        end
    endtask

    task automatic test_zero_len();
        int n;
        push_hdr(32'h0000_0000);
        do_start(16'd0);
        wait_clear(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL aclr_cycles: got %0d, expected 4", n);
        end
        wait_done(50);
    endtask

    task automatic test_clamp();
        int n;
        for (int k = 0; k < 4096; k++) push(16'(500 + k), {16'(k), ~16'(k)});
        push_hdr(32'h0000_1000);
        do_start(16'd5000);
        wait_clear(n);
        for (int k = 0; k < 4096; k++) begin
            idata     = 16'(k);
            qdata     = ~16'(k);
            iq_valid  = 1'b1;
            start     = (k == 100) || (k == 2000);
            pulse_len = 16'd3;
            tick();
            start = 1'b0;
            if (k == 100) begin
                checks++;
                if (busy !== 1'b1 || fifo_aclr !== 1'b0) begin
                    errors++;
                    $display("FAIL start_ignored: got busy=%b aclr=%b, expected 1 0",
                             busy, fifo_aclr);
                end
            end
        end
        iq_valid = 1'b0;
        wait_done(50);
        checks++;
        if (sample_cnt !== 16'd4096 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL clamp_status: got cnt=%0d ovr=%b, expected 4096 0", sample_cnt, overrun);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        push(16'd500, 32'h1111_2222);
        push(16'd501, 32'h3333_4444);
        do_start(16'd4);
        wait_clear(n);
        idata = 16'h1111; qdata = 16'h2222; iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        tick();
        idata = 16'h3333; qdata = 16'h4444; iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({wr_en, busy, done, overrun, fifo_aclr} !== 5'b00001 || sample_cnt !== 16'd0 ||
            wr_addr !== 16'd0 || wr_data !== 32'd0) begin
            errors++;
            $display("FAIL abort_state: got en=%b busy=%b done=%b ovr=%b aclr=%b cnt=%h, expected 0 0 0 0 1 0",
                     wr_en, busy, done, overrun, fifo_aclr, sample_cnt);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_pending: got %0d pending busy=%b, expected 0 0", sb.size(), busy);
        end
        push(16'd500, 32'h5555_6666);
        push_hdr(32'h0000_0001);
        do_start(16'd1);
        wait_clear(n);
        idata = 16'h5555; qdata = 16'h6666; iq_valid = 1'b1;
        tick();
        iq_valid = 1'b0;
        wait_done(50);
    endtask

    task automatic test_back_to_back();
        int n;
        for (int i = 0; i < 4; i++) push(16'(500 + i), {16'(i + 8), 16'(i + 64)});
        push_hdr(32'h0000_0004);
        do_start(16'd4);
        wait_clear(n);
        wr_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            idata    = 16'(i + 8);
            qdata    = 16'(i + 64);
            iq_valid = 1'b1;
            tick();
        end
        iq_valid = 1'b0;
        wait_done(50);
        checks++;
        if (wr_cyc.size() < 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes, expected at least 4", wr_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_cyc[i + 1] != wr_cyc[i] + 1) begin
                    errors++;
                    $display("FAIL b2b_gap: got write %0d at cycle %0d after %0d, expected consecutive",
                             i + 1, wr_cyc[i + 1], wr_cyc[i]);
                end
            end
        end
        checks++;
        if (overrun !== 1'b0 || sample_cnt !== 16'd4) begin
            errors++;
            $display("FAIL b2b_status: got ovr=%b cnt=%0d, expected 0 4", overrun, sample_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_zero_len();
        test_clamp();
        test_reset_abort();
        test_back_to_back();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d still expected, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
